// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: AXI4-Lite slave over a word-organised, byte-strobed RAM.
// Latency: RVALID rises RD_LATENCY edges after the AR handshake; BVALID rises
//   one edge after both AW and W have been captured.
// Backpressure: one outstanding read and one outstanding write; each ready is
//   held low until the matching R/B handshake completes.
// Ports: clk/reset (async, active-high); AR/R read channel; AW/W/B write channel.
// Optional: define AXI_MEM_BACKPRESSURE_EN to add LFSR-driven ready throttling.
module axi_lite_mem_slave #(
  parameter int MEM_AW     = 6,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ARADDR,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  input  logic        RREADY,
  input  logic [31:0] AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_LAT, R_RESP} r_state_t;
  typedef enum logic       {W_COLLECT, W_RESP}     w_state_t;

  logic [31:0] mem_q [DEPTH];

  // Ready throttle; constant zero unless the backpressure option is built in.
  logic stall;

`ifdef AXI_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr_q;
  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // ---------------- read path ----------------
  r_state_t          r_state_q;
  logic              arready_q, rvalid_q, ar_ok_q;
  logic [MEM_AW-1:0] ar_idx_q;
  logic [3:0]        lat_cnt_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;

  assign ARREADY = arready_q & ~stall;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= RESP_OKAY;
      ar_ok_q   <= 1'b0;
      ar_idx_q  <= '0;
      lat_cnt_q <= 4'd0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ARVALID && ARREADY) begin
            ar_idx_q  <= ARADDR[MEM_AW+1:2];
            ar_ok_q   <= ((ARADDR >> (MEM_AW + 2)) == 32'd0);
            arready_q <= 1'b0;
            lat_cnt_q <= 4'(RD_LATENCY - 1);
            r_state_q <= R_LAT;
          end
        end
        R_LAT: begin
          if (lat_cnt_q == 4'd0) begin
            // mem_q is sampled here, so a write committing on this same edge
            // is not yet visible.
            rvalid_q  <= 1'b1;
            rdata_q   <= ar_ok_q ? mem_q[ar_idx_q] : 32'd0;
            rresp_q   <= ar_ok_q ? RESP_OKAY : RESP_SLVERR;
            r_state_q <= R_RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- write path ----------------
  w_state_t          w_state_q;
  logic              awready_q, wready_q, bvalid_q;
  logic              aw_got_q, w_got_q, aw_ok_q;
  logic [MEM_AW-1:0] aw_idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [1:0]        bresp_q;
  logic              mem_we_d;

  assign AWREADY = awready_q & ~stall;
  assign WREADY  = wready_q & ~stall;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q <= W_COLLECT;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_ok_q   <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
    end else begin
      case (w_state_q)
        W_COLLECT: begin
          if (aw_got_q && w_got_q) begin
            // Memory is written on this same edge (see mem_we_d).
            bvalid_q  <= 1'b1;
            bresp_q   <= aw_ok_q ? RESP_OKAY : RESP_SLVERR;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            w_state_q <= W_RESP;
          end else begin
            if (AWVALID && AWREADY) begin
              aw_idx_q  <= AWADDR[MEM_AW+1:2];
              aw_ok_q   <= ((AWADDR >> (MEM_AW + 2)) == 32'd0);
              aw_got_q  <= 1'b1;
              awready_q <= 1'b0;
            end
            if (WVALID && WREADY) begin
              wdata_q  <= WDATA;
              wstrb_q  <= WSTRB;
              w_got_q  <= 1'b1;
              wready_q <= 1'b0;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_COLLECT;
          end
        end
        default: w_state_q <= W_COLLECT;
      endcase
    end
  end

  // Enable derives only from asynchronously reset state, so a reset in flight
  // can never leave a partial write behind.
  assign mem_we_d = (w_state_q == W_COLLECT) && aw_got_q && w_got_q && aw_ok_q && !reset;

  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem_q[aw_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
module tb_axi_lite_mem_slave;
  localparam int MAW = 6;
  localparam int RDL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [1:0]  RRESP, BRESP;
  logic [3:0]  WSTRB;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [64];

  always #5 clk = ~clk;

  axi_lite_mem_slave #(.MEM_AW(MAW), .RD_LATENCY(RDL)) dut (
    .clk(clk), .reset(reset),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >> (MAW + 2)) == 32'd0;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'(a[MAW+1:2]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full AW/W/B exchange; aw_d / w_d delay each VALID in cycles, bhold holds BREADY low.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_d, input int w_d, input int bhold);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int t = 0;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    while (!(aw_done && w_done) && t < 50) begin
      AWVALID = !aw_done && (t >= aw_d);
      WVALID  = !w_done && (t >= w_d);
      if (aw_done) check("awready_after_capture", AWREADY, 0);
      if (w_done)  check("wready_after_capture", WREADY, 0);
      check("bvalid_before_both", BVALID, 0);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      t++;
    end
    AWVALID = 0; WVALID = 0;
    check("wr_accept_timeout", {30'd0, aw_done, w_done}, 32'd3);
    check("bvalid_on_capture_edge", BVALID, 0);
    tick();
    check("bvalid_rise", BVALID, 1);
    check("bresp", BRESP, in_range(addr) ? 2'b00 : 2'b10);
    if (in_range(addr))
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[word_of(addr)][8*b +: 8] = data[8*b +: 8];
    for (int i = 0; i < bhold; i++) begin
      tick();
      check("bvalid_held", BVALID, 1);
      check("awready_during_b", AWREADY, 0);
      check("wready_during_b", WREADY, 0);
    end
    BREADY = 1;
    tick();
    BREADY = 0;
    check("bvalid_after_b", BVALID, 0);
    check("awready_after_b", AWREADY, 1);
    check("wready_after_b", WREADY, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int rhold, output logic [31:0] seen);
    int lat = 0;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    exp_d = in_range(addr) ? model[word_of(addr)] : 32'd0;
    exp_r = in_range(addr) ? 2'b00 : 2'b10;
    ARADDR = addr; ARVALID = 1;
    check("arready_idle", ARREADY, 1);
    tick();
    ARVALID = 0;
    check("arready_after_ar", ARREADY, 0);
    while (!RVALID && lat < 40) begin
      tick();
      lat++;
    end
    check("rd_latency", lat, RDL);
    seen = RDATA;
    check("rdata", RDATA, exp_d);
    check("rresp", RRESP, exp_r);
    for (int i = 0; i < rhold; i++) begin
      tick();
      check("rdata_held", RDATA, exp_d);
      check("rvalid_held", RVALID, 1);
      check("arready_during_r", ARREADY, 0);
    end
    RREADY = 1;
    tick();
    RREADY = 0;
    check("rvalid_after_r", RVALID, 0);
    check("arready_after_r", ARREADY, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a, old;
    reset = 1;
    ARADDR = 0; ARVALID = 0; RREADY = 0;
    AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
    tick(); tick();
    check("rst_arready", ARREADY, 1);
    check("rst_awready", AWREADY, 1);
    check("rst_wready", WREADY, 1);
    check("rst_rvalid", RVALID, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_rresp", RRESP, 0);
    check("rst_bresp", BRESP, 0);
    reset = 0;
    tick();

    // Give every word a known value so any later read has a defined answer.
    for (int i = 0; i < 64; i++) do_write(32'(i * 4), $urandom, 4'hF, 0, 0, 0);

    // Basic write then read.
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(32'h10, 0, rd);
    check("basic_value", rd, 32'hDEADBEEF);

    // Byte strobes.
    do_write(32'h20, 32'h11223344, 4'hF, 0, 0, 0);
    do_write(32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    do_read(32'h20, 0, rd);
    check("strobe_value", rd, 32'h11BB33DD);

    // Empty strobe leaves the word alone.
    do_write(32'h20, 32'h55555555, 4'b0000, 0, 0, 0);
    do_read(32'h20, 0, rd);
    check("nostrobe_value", rd, 32'h11BB33DD);

    // Channel ordering: W first, then AW first.
    do_write(32'h08, 32'hCAFEF00D, 4'hF, 3, 0, 0);
    do_read(32'h08, 0, rd);
    check("w_first_value", rd, 32'hCAFEF00D);
    do_write(32'h08, 32'h0BADC0DE, 4'hF, 0, 3, 0);
    do_read(32'h08, 0, rd);
    check("aw_first_value", rd, 32'h0BADC0DE);

    // Out-of-range accesses.
    old = model[0];
    do_write(32'h100, 32'h12345678, 4'hF, 0, 0, 0);
    do_read(32'h0, 0, rd);
    check("oor_word0_unchanged", rd, old);
    do_read(32'h1FC, 0, rd);
    check("oor_read_zero", rd, 32'd0);

    // Response-channel backpressure.
    do_read(32'h10, 5, rd);
    do_write(32'h14, 32'hA5A5A5A5, 4'hF, 0, 0, 4);

    // Randomized mix against the reference model.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h100;
      else a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 3), rd);
    end

    // Reset while the read sits in its latency countdown.
    ARADDR = 32'h10; ARVALID = 1;
    tick();
    ARVALID = 0;
    tick();
    reset = 1;
    #1;
    check("rstrd_rvalid", RVALID, 0);
    check("rstrd_arready", ARREADY, 1);
    tick();
    reset = 0;
    tick();
    do_read(32'h10, 0, rd);

    // Reset between capture and commit of a write: no update may land.
    old = model[12];
    AWADDR = 32'h30; WDATA = ~old; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    tick();
    AWVALID = 0; WVALID = 0;
    reset = 1;
    #1;
    check("rstwr_bvalid", BVALID, 0);
    check("rstwr_awready", AWREADY, 1);
    check("rstwr_wready", WREADY, 1);
    tick();
    reset = 0;
    tick();
    do_read(32'h30, 0, rd);
    check("rstwr_word_intact", rd, old);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
